// File: rtl/id_stage_fwd_pkg.sv
// id_stage_fwd_pkg: shared constants, decode record and decode function for the ID stage
package id_stage_fwd_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W = 64;
  localparam int ALUOP_W = 8;
  localparam int ALUSEL_W = 3;
  localparam logic [3:0] MEM_SREG = 4'h1;
  localparam logic [3:0] MEM_DREG = 4'h2;
  localparam logic [7:0] EXE_AND = 8'h24;
  localparam logic [7:0] EXE_OR = 8'h25;
  localparam logic [ALUOP_W-1:0] EXE_NOP_OP = 8'h00;
  localparam logic [ALUOP_W-1:0] EXE_AND_OP = 8'h24;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP = 8'h25;
  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP = 3'b000;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam int NOP_REG_ADDR = 0;
  typedef struct packed {
    logic legal;
    logic rd1;
    logic rd2;
    logic sreg;
    logic wreg;
    logic [ALUOP_W-1:0] aluop;
    logic [ALUSEL_W-1:0] alusel;
  } dec_t;
  function automatic dec_t decode(logic [3:0] mem, logic [7:0] op);
    dec_t d;
    d.legal = (mem == MEM_SREG || mem == MEM_DREG) && (op == EXE_OR || op == EXE_AND);
    d.rd1 = d.legal;
    d.rd2 = d.legal && mem == MEM_DREG;
    d.sreg = d.legal && mem == MEM_SREG;
    d.wreg = d.legal;
    d.aluop = !d.legal ? EXE_NOP_OP : op == EXE_OR ? EXE_OR_OP : EXE_AND_OP;
    d.alusel = d.legal ? EXE_RES_LOGIC : EXE_RES_NOP;
    return d;
  endfunction
endpackage

// File: rtl/id_stage_fwd_if.sv
// id_stage_fwd_if: IF/ID input handshake and registered ID/EX output bus; master = ID stage, slave = its surroundings
interface id_stage_fwd_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  import id_stage_fwd_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [INST_ADDR_W-1:0] in_pc;
  logic [INST_W-1:0] inst;
  logic out_valid;
  logic out_ready;
  logic [INST_ADDR_W-1:0] pc;
  logic [ALUOP_W-1:0] aluop;
  logic [ALUSEL_W-1:0] alusel;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;
  logic [REG_AW-1:0] wd;
  logic wreg;
  logic illegal;
  modport master (
    input in_valid, in_pc, inst, out_ready,
    output in_ready, out_valid, pc, aluop, alusel, reg1, reg2, wd, wreg, illegal
  );
  modport slave (
    output in_valid, in_pc, inst, out_ready,
    input in_ready, out_valid, pc, aluop, alusel, reg1, reg2, wd, wreg, illegal
  );
endinterface

// File: rtl/id_stage_fwd_mux.sv
// id_fwd_mux: one operand's prioritised forwarding mux (channel 0 youngest wins) plus its load-in-flight hit flag
module id_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                      rd,
  input  logic [REG_AW-1:0]         addr,
  input  logic [DATA_W-1:0]         rf_data,
  input  logic [DATA_W-1:0]         dflt,
  input  logic [NUM_FWD-1:0]        fwd_wreg,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wd,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_load,
  output logic [DATA_W-1:0]         data,
  output logic                      load_hit
);
  logic [DATA_W-1:0] fdata;
  logic fload;
  logic fwd_ok;
  // walk oldest to youngest so the lowest matching index is the last writer
  always_comb begin
    fdata = rf_data;
    fload = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--)
      if (fwd_wreg[k] && fwd_wd[k*REG_AW +: REG_AW] == addr) begin
        fdata = fwd_wdata[k*DATA_W +: DATA_W];
        fload = fwd_load[k];
      end
  end
  assign fwd_ok = rd && addr != '0;
  assign data = !rd ? dflt : fwd_ok ? fdata : rf_data;
  assign load_hit = fwd_ok && fload;
endmodule

// File: rtl/id_stage_fwd.sv
// id_stage_fwd: decode stage with forwarding, load-use bubble insertion and registered ID/EX output
// Ports: clk/rst (async active-high); bus = IF/ID in + ID/EX out handshake; reg*_addr/read/data = regfile;
//        fwd_* = per-channel forwarding (0 youngest); stall_cnt = saturating load-use stall count
module id_stage_fwd
  import id_stage_fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NUM_FWD = 2,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  id_stage_fwd_if.master            bus,
  output logic [REG_AW-1:0]         reg1_addr,
  output logic [REG_AW-1:0]         reg2_addr,
  output logic                      reg1_read,
  output logic                      reg2_read,
  input  logic [DATA_W-1:0]         reg1_data,
  input  logic [DATA_W-1:0]         reg2_data,
  input  logic [NUM_FWD-1:0]        fwd_wreg,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wd,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_load,
  output logic [CNT_W-1:0]          stall_cnt
);
  dec_t dec;
  logic [DATA_W-1:0] imm, op1, op2;
  logic hit1, hit2, hz, adv;
  logic unused_bits;
  assign dec = decode(bus.inst[63:60], bus.inst[59:52]);
  assign imm = DATA_W'(bus.inst[41:10]);
  assign reg1_addr = REG_AW'(bus.inst[46:42]);
  assign reg2_addr = REG_AW'(bus.inst[41:37]);
  assign reg1_read = dec.rd1;
  assign reg2_read = dec.rd2;
  assign unused_bits = ^bus.inst[9:0];
  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_mux1 (
    .rd(dec.rd1), .addr(reg1_addr), .rf_data(reg1_data), .dflt('0),
    .fwd_wreg(fwd_wreg), .fwd_wd(fwd_wd), .fwd_wdata(fwd_wdata), .fwd_load(fwd_load),
    .data(op1), .load_hit(hit1)
  );
  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_mux2 (
    .rd(dec.rd2), .addr(reg2_addr), .rf_data(reg2_data), .dflt(dec.sreg ? imm : '0),
    .fwd_wreg(fwd_wreg), .fwd_wd(fwd_wd), .fwd_wdata(fwd_wdata), .fwd_load(fwd_load),
    .data(op2), .load_hit(hit2)
  );
  assign hz = bus.in_valid && (hit1 || hit2);
  assign adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv && !hz;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.pc <= '0;
      bus.aluop <= EXE_NOP_OP;
      bus.alusel <= EXE_RES_NOP;
      bus.reg1 <= '0;
      bus.reg2 <= '0;
      bus.wd <= REG_AW'(NOP_REG_ADDR);
      bus.wreg <= 1'b0;
      bus.illegal <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (adv) begin
        if (hz) begin
          bus.out_valid <= 1'b0;
          bus.wreg <= 1'b0;
          bus.aluop <= EXE_NOP_OP;
        end else if (bus.in_valid) begin
          bus.out_valid <= 1'b1;
          bus.pc <= bus.in_pc;
          bus.aluop <= dec.aluop;
          bus.alusel <= dec.alusel;
          bus.reg1 <= op1;
          bus.reg2 <= op2;
          bus.wd <= dec.legal ? REG_AW'(bus.inst[51:47]) : REG_AW'(NOP_REG_ADDR);
          bus.wreg <= dec.wreg;
          bus.illegal <= !dec.legal;
        end else
          bus.out_valid <= 1'b0;
      end
      if (hz && adv && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_id_stage_fwd.sv
// tb_id_stage_fwd: directed self-checking bench for id_stage_fwd
module tb_id_stage_fwd;
  import id_stage_fwd_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] reg1_addr, reg2_addr;
  logic reg1_read, reg2_read;
  logic [31:0] reg1_data, reg2_data;
  logic [1:0] fwd_wreg, fwd_load;
  logic [9:0] fwd_wd;
  logic [63:0] fwd_wdata;
  logic [15:0] stall_cnt;
  logic [31:0] rf [32];
  int n_cmp = 0;
  int n_err = 0;
  id_stage_fwd_if #(.DATA_W(32), .REG_AW(5)) bus ();
  id_stage_fwd #(.DATA_W(32), .REG_AW(5), .NUM_FWD(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .reg1_addr(reg1_addr), .reg2_addr(reg2_addr), .reg1_read(reg1_read), .reg2_read(reg2_read),
    .reg1_data(reg1_data), .reg2_data(reg2_data),
    .fwd_wreg(fwd_wreg), .fwd_wd(fwd_wd), .fwd_wdata(fwd_wdata), .fwd_load(fwd_load),
    .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  assign reg1_data = rf[reg1_addr];
  assign reg2_data = rf[reg2_addr];

  function automatic logic [63:0] mk(logic [3:0] m, logic [7:0] o, logic [4:0] wd, logic [4:0] rs1, logic [31:0] imm);
    return {m, o, wd, rs1, imm, 10'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.inst = '0; bus.out_ready = 1'b1;
    fwd_wreg = '0; fwd_wd = '0; fwd_wdata = '0; fwd_load = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    step(); step();
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %h want 0", bus.out_valid); end
    n_cmp++; if (bus.aluop !== EXE_NOP_OP) begin n_err++; $display("FAIL reset_aluop got %h want %h", bus.aluop, EXE_NOP_OP); end
    n_cmp++; if ({bus.wd, bus.wreg, bus.reg1, bus.reg2, bus.pc, bus.illegal} !== '0) begin n_err++; $display("FAIL reset_fields got nonzero want 0"); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %h want 1", bus.in_ready); end
  endtask

  task automatic test_sreg_or();
    rf[1] = 32'h0000_F0F0;
    bus.in_valid = 1'b1; bus.in_pc = 32'h100;
    bus.inst = mk(MEM_SREG, EXE_OR, 5'd5, 5'd1, 32'h0000_0F0F);
    #1;
    n_cmp++; if ({reg1_read, reg2_read, reg1_addr} !== {1'b1, 1'b0, 5'd1}) begin n_err++; $display("FAIL sreg_read got %b%b %0d want 10 1", reg1_read, reg2_read, reg1_addr); end
    step();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL sreg_valid got %h want 1", bus.out_valid); end
    n_cmp++; if (bus.reg1 !== 32'h0000_F0F0) begin n_err++; $display("FAIL sreg_reg1 got %h want 0000f0f0", bus.reg1); end
    n_cmp++; if (bus.reg2 !== 32'h0000_0F0F) begin n_err++; $display("FAIL sreg_reg2 got %h want 00000f0f", bus.reg2); end
    n_cmp++; if ({bus.aluop, bus.alusel, bus.wreg, bus.wd, bus.illegal} !== {EXE_OR_OP, EXE_RES_LOGIC, 1'b1, 5'd5, 1'b0}) begin n_err++; $display("FAIL sreg_ctrl got %h %h %h %0d %h want 25 1 1 5 0", bus.aluop, bus.alusel, bus.wreg, bus.wd, bus.illegal); end
    n_cmp++; if (bus.pc !== 32'h100) begin n_err++; $display("FAIL sreg_pc got %h want 100", bus.pc); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL sreg_drain got %h want 0", bus.out_valid); end
  endtask

  task automatic test_dreg_and();
    rf[2] = 32'h0BAD_0002; rf[3] = 32'h1234_5678;
    fwd_wreg = 2'b11; fwd_wd = {5'd2, 5'd2}; fwd_wdata = {32'h5555_5555, 32'hAAAA_AAAA};
    bus.in_valid = 1'b1; bus.in_pc = 32'h104;
    bus.inst = mk(MEM_DREG, EXE_AND, 5'd6, 5'd2, {5'd3, 27'b0});
    step();
    n_cmp++; if (bus.reg1 !== 32'hAAAA_AAAA) begin n_err++; $display("FAIL dreg_ch0_wins got %h want aaaaaaaa", bus.reg1); end
    n_cmp++; if (bus.reg2 !== 32'h1234_5678) begin n_err++; $display("FAIL dreg_rf_reg2 got %h want 12345678", bus.reg2); end
    n_cmp++; if (bus.aluop !== EXE_AND_OP) begin n_err++; $display("FAIL dreg_aluop got %h want %h", bus.aluop, EXE_AND_OP); end
    rf[3] = 32'h0;
    fwd_wd = {5'd3, 5'd7}; fwd_wdata = {32'h1234_5678, 32'hAAAA_AAAA};
    step();
    n_cmp++; if (bus.reg1 !== 32'h0BAD_0002) begin n_err++; $display("FAIL dreg_nomatch got %h want 0bad0002", bus.reg1); end
    n_cmp++; if (bus.reg2 !== 32'h1234_5678) begin n_err++; $display("FAIL dreg_ch1_reg2 got %h want 12345678", bus.reg2); end
    bus.in_valid = 1'b0; fwd_wreg = '0;
    step();
  endtask

  task automatic test_r0();
    rf[0] = 32'h0000_0011;
    fwd_wreg = 2'b01; fwd_wd = {5'd9, 5'd0}; fwd_wdata = {32'h0, 32'hDEAD_BEEF};
    bus.in_valid = 1'b1; bus.in_pc = 32'h108;
    bus.inst = mk(MEM_SREG, EXE_OR, 5'd1, 5'd0, 32'h0);
    step();
    bus.in_valid = 1'b0; fwd_wreg = '0;
    n_cmp++; if (bus.reg1 !== 32'h0000_0011) begin n_err++; $display("FAIL r0_noforward got %h want 00000011", bus.reg1); end
    step();
  endtask

  task automatic test_load_use();
    fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd4}; fwd_wdata = {32'h0, 32'hFFFF_0000}; fwd_load = 2'b01;
    bus.in_valid = 1'b1; bus.in_pc = 32'h10C;
    bus.inst = mk(MEM_SREG, EXE_OR, 5'd8, 5'd4, 32'h1);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL lu_in_ready got %h want 0", bus.in_ready); end
    step();
    n_cmp++; if ({bus.out_valid, bus.wreg, bus.aluop} !== {1'b0, 1'b0, EXE_NOP_OP}) begin n_err++; $display("FAIL lu_bubble got %h %h %h want 0 0 0", bus.out_valid, bus.wreg, bus.aluop); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_stall got %0d want 1", stall_cnt); end
    fwd_load = 2'b00; fwd_wdata = {32'h0, 32'h0000_0077};
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL lu_release got %h want 1", bus.in_ready); end
    step();
    n_cmp++; if ({bus.out_valid, bus.reg1, bus.reg2} !== {1'b1, 32'h77, 32'h1}) begin n_err++; $display("FAIL lu_issue got %h %h %h want 1 77 1", bus.out_valid, bus.reg1, bus.reg2); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_stall_hold got %0d want 1", stall_cnt); end
    fwd_wreg = 2'b11; fwd_wd = {5'd4, 5'd4}; fwd_load = 2'b10;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL lu_younger_shadows got %h want 1", bus.in_ready); end
    bus.in_valid = 1'b0; fwd_wreg = '0; fwd_load = '0;
    step();
  endtask

  task automatic test_back_pressure();
    rf[10] = 32'h0000_00A0; rf[11] = 32'h0000_00B0;
    bus.in_valid = 1'b1; bus.in_pc = 32'h200;
    bus.inst = mk(MEM_SREG, EXE_AND, 5'd3, 5'd10, 32'h5);
    step();
    bus.out_ready = 1'b0; bus.in_pc = 32'h300;
    bus.inst = mk(MEM_SREG, EXE_OR, 5'd4, 5'd11, 32'h6);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready%0d got %h want 0", i, bus.in_ready); end
      step();
      n_cmp++; if ({bus.out_valid, bus.pc, bus.reg1, bus.reg2, bus.aluop, bus.wd} !== {1'b1, 32'h200, 32'hA0, 32'h5, EXE_AND_OP, 5'd3}) begin n_err++; $display("FAIL bp_hold%0d got %h %h %h want 1 200 a0", i, bus.out_valid, bus.pc, bus.reg1); end
    end
    bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got %h want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    n_cmp++; if ({bus.pc, bus.reg1, bus.aluop} !== {32'h300, 32'hB0, EXE_OR_OP}) begin n_err++; $display("FAIL bp_transfer got %h %h %h want 300 b0 25", bus.pc, bus.reg1, bus.aluop); end
    step();
  endtask

  task automatic test_illegal();
    bus.in_valid = 1'b1; bus.in_pc = 32'h400;
    bus.inst = mk(MEM_DREG, 8'hFF, 5'd7, 5'd1, {5'd2, 27'b0});
    step();
    bus.in_valid = 1'b0;
    n_cmp++; if ({bus.out_valid, bus.illegal, bus.wreg, bus.aluop, bus.alusel} !== {1'b1, 1'b1, 1'b0, EXE_NOP_OP, EXE_RES_NOP}) begin n_err++; $display("FAIL illegal got %h %h %h %h want 1 1 0 0", bus.out_valid, bus.illegal, bus.wreg, bus.aluop); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({bus.out_valid, bus.illegal, bus.pc, bus.reg1, stall_cnt} !== '0) begin n_err++; $display("FAIL async_reset got %h %h %h %h want 0", bus.out_valid, bus.illegal, bus.pc, stall_cnt); end
    @(negedge clk);
    rst = 1'b0;
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL async_no_replay got %h want 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_sreg_or();
    test_dreg_and();
    test_r0();
    test_load_use();
    test_back_pressure();
    test_illegal();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
